if_id_skid_stage: RTL and testbench
===================================

Name: if_id_skid_stage

Overview:
- Parametrised IF/ID pipeline stage with valid/ready handshake, a 2-entry skid buffer, flush, and immediate extension.
- Sits between the fetch unit and the decode stage.
- Lets decode back-pressure fetch (hazard stall) without losing a fetched instruction; branch flush squashes in-flight entries into NOPs.
- Adds a saturating flush counter for performance visibility.

Parameters:
- INST_W, 32, instruction width in bits.
- PC_W, 10, program-counter width in bits.
- IMM_W, 16, immediate field width, taken from inst[IMM_W-1:0].
- EXT_SIGN, 0, immediate extension mode: 0 = zero-extend, 1 = sign-extend.
- CNT_W, 16, flush-counter width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept; equals !skid_valid, driven from a register.
- in_inst  input  INST_W  fetched instruction.
- in_pc  input  PC_W  PC of fetched instruction.
- flush  input  1  squash all held entries and this cycle's input.
- out_valid  output  1  main entry valid.
- out_ready  input  1  decode consumes main entry; 0 = stall.
- out_inst  output  INST_W  main-entry instruction, 0 (NOP) when !out_valid.
- out_pc  output  PC_W  main-entry PC.
- out_imm  output  INST_W  extended immediate of out_inst, combinational from main register.
- flush_cnt  output  CNT_W  count of effective flushes.

Behaviour:
- Storage: main {valid, inst, pc}; skid {valid, inst, pc}.
- State is implied: EMPTY (main invalid), ONE (main valid, skid invalid), TWO (both valid).
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready. Latency is 1 cycle from in-transfer to out_valid when the stage is not stalled.
- EMPTY: in_valid -> load main -> ONE. out_ready is ignored.
- ONE:
  - out_ready & in_valid -> main <= input, stay ONE.
  - out_ready & !in_valid -> EMPTY.
  - !out_ready & in_valid -> skid <= input -> TWO.
  - !out_ready & !in_valid -> hold.
- TWO:
  - in_ready = 0; in_valid is ignored and no data is captured.
  - out_ready -> main <= skid, skid invalid -> ONE.
  - Otherwise hold.
- Ordering: strictly FIFO; skid content always precedes any later input.
- Flush (highest priority):
  - Next cycle, main.valid = skid.valid = 0 (EMPTY).
  - Same-cycle input is dropped even if in_valid=1.
  - out_inst reads 0 from the next cycle; out_pc retains its last value.
  - A simultaneous out-transfer in the flush cycle is still considered consumed by decode.
- flush_cnt increments by 1 on each flush cycle where state != EMPTY or in_valid=1. It saturates at all-ones and does not wrap.
- out_inst = main.valid ? main.inst : 0.
- out_imm:
  - EXT_SIGN=0: {zeros, out_inst[IMM_W-1:0]}.
  - EXT_SIGN=1: replicate out_inst[IMM_W-1].
- Reset (rst=1 at a clock edge):
  - Both valids 0, all data registers 0, in_ready=1, out_valid=0, out_inst=0, out_pc=0, flush_cnt=0.
  - Reset overrides flush and all transfers.
  - Reset mid-stall discards both entries.
- Data registers load only on the transfers above; no spurious updates when an entry is invalid.

Decomposition:
- Shared package pipe_pkg:
  - NOP_INST constant (all zero).
  - stage_state_e enum {EMPTY, ONE, TWO}, for assertions and debug.
  - Typedef for the {valid, inst, pc} entry struct.
- One natural sub-module: imm_ext (combinational; params IMM_W, OUT_W, EXT_SIGN). Reused by later stages.

Test Plan:
- Reset, then in_valid=1, in_inst=32'h2002_0005, in_pc=10'd4, out_ready=1 -> next cycle out_valid=1, out_inst=32'h2002_0005, out_pc=4, out_imm=32'h0000_0005.
- Stall: out_ready=0; push A (pc 8) and B (pc 12) -> in_ready=0 after B; push C while in_ready=0 -> ignored. Release out_ready -> outputs A, then B, then EMPTY; C never appears.
- Flush in TWO with in_valid=1 -> next cycle out_valid=0, out_inst=0, in_ready=1, flush_cnt=1. Flush while EMPTY with in_valid=0 -> flush_cnt unchanged.
- EXT_SIGN=1, inst[15:0]=16'hFFFC -> out_imm=32'hFFFF_FFFC. EXT_SIGN=0 with the same inst -> 32'h0000_FFFC.
- CNT_W=2: apply 5 effective flushes -> flush_cnt sticks at 3.
- Assert rst during TWO with flush=1 -> all outputs return to reset values next cycle, flush_cnt=0. First push after reset is accepted.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the in-order pipeline stages.
// Widths below describe the default configuration used by benches and debug views.
package pipe_pkg;

    localparam int DEF_INST_W = 32;
    localparam int DEF_PC_W   = 10;

    localparam logic [DEF_INST_W-1:0] NOP_INST = '0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic                  valid;
        logic [DEF_INST_W-1:0] inst;
        logic [DEF_PC_W-1:0]   pc;
    } entry_t;

endpackage

// File: rtl/if_id_skid_stage_imm_ext.sv
// Immediate extender: widens an IMM_W field to OUT_W bits, zero- or sign-filled.
module imm_ext #(
    parameter int IMM_W    = 16,
    parameter int OUT_W    = 32,
    parameter bit EXT_SIGN = 1'b0
) (
    input  logic [IMM_W-1:0] imm,
    output logic [OUT_W-1:0] ext
);

    generate
        if (OUT_W > IMM_W) begin : g_wide
            logic fill;
            assign fill = EXT_SIGN ? imm[IMM_W-1] : 1'b0;
            assign ext  = {{(OUT_W-IMM_W){fill}}, imm};
        end else begin : g_same
            assign ext = imm[OUT_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID stage: main register plus one skid entry so decode can stall without losing a fetch.
// Flush empties both entries and drops the same-cycle input; flush_cnt saturates.
module if_id_skid_stage
    import pipe_pkg::*;
#(
    parameter int INST_W   = 32,
    parameter int PC_W     = 10,
    parameter int IMM_W    = 16,
    parameter bit EXT_SIGN = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_imm,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } slot_t;

    slot_t        main_q;
    slot_t        skid_q;
    slot_t        in_slot;
    stage_state_e state;
    logic [CNT_W-1:0] cnt_q;

    // skid is only ever filled behind a valid main entry
    always_comb begin
        state = EMPTY;
        if (main_q.valid) state = skid_q.valid ? TWO : ONE;
    end

    assign in_slot = '{valid: 1'b1, inst: in_inst, pc: in_pc};

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            // data fields keep their contents so out_pc holds its last value
            main_q.valid <= 1'b0;
            skid_q.valid <= 1'b0;
            if ((state != EMPTY || in_valid) && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            case (state)
                EMPTY: if (in_valid) main_q <= in_slot;
                ONE: begin
                    if (out_ready) begin
                        if (in_valid) main_q <= in_slot;
                        else          main_q.valid <= 1'b0;
                    end else if (in_valid) begin
                        skid_q <= in_slot;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        main_q       <= skid_q;
                        skid_q.valid <= 1'b0;
                    end
                end
                default: begin
                    main_q <= '0;
                    skid_q <= '0;
                end
            endcase
        end
    end

    assign in_ready  = ~skid_q.valid;
    assign out_valid = main_q.valid;
    assign out_inst  = main_q.valid ? main_q.inst : INST_W'(NOP_INST);
    assign out_pc    = main_q.pc;
    assign flush_cnt = cnt_q;

    imm_ext #(
        .IMM_W   (IMM_W),
        .OUT_W   (INST_W),
        .EXT_SIGN(EXT_SIGN)
    ) u_imm_ext (
        .imm(out_inst[IMM_W-1:0]),
        .ext(out_imm)
    );

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed + random bench for if_id_skid_stage with a FIFO scoreboard model.
// Three instances share stimulus: default, sign-extending, and a 2-bit flush counter.
module tb_if_id_skid_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [9:0]  in_pc;
    logic        flush;
    logic        out_ready;

    logic        in_ready0, out_valid0, in_ready_s, out_valid_s, in_ready_c, out_valid_c;
    logic [31:0] out_inst0, out_imm0, out_inst_s, out_imm_s, out_inst_c, out_imm_c;
    logic [9:0]  out_pc0, out_pc_s, out_pc_c;
    logic [15:0] flush_cnt0, flush_cnt_s;
    logic [1:0]  flush_cnt_c;

    int checks = 0;
    int errors = 0;

    entry_t      sb[$];
    logic [9:0]  m_pc;
    logic [15:0] m_cnt;
    logic [1:0]  m_cnt_c;

    always #5 clk = ~clk;

    if_id_skid_stage dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid0),
        .out_ready(out_ready), .out_inst(out_inst0), .out_pc(out_pc0),
        .out_imm(out_imm0), .flush_cnt(flush_cnt0)
    );

    if_id_skid_stage #(.EXT_SIGN(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_inst(out_inst_s), .out_pc(out_pc_s),
        .out_imm(out_imm_s), .flush_cnt(flush_cnt_s)
    );

    if_id_skid_stage #(.CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid_c),
        .out_ready(out_ready), .out_inst(out_inst_c), .out_pc(out_pc_c),
        .out_imm(out_imm_c), .flush_cnt(flush_cnt_c)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Compare current outputs with the model, then advance model and clock together.
    task automatic cycle();
        logic [31:0] e_inst;
        int          n;
        n      = sb.size();
        e_inst = (n > 0) ? sb[0].inst : 32'h0;
        check("out_valid", 64'(out_valid0), 64'(n > 0));
        check("in_ready",  64'(in_ready0),  64'(n < 2));
        check("out_inst",  64'(out_inst0),  64'(e_inst));
        check("out_pc",    64'(out_pc0),    64'(m_pc));
        check("imm_zero",  64'(out_imm0),   64'({16'h0, e_inst[15:0]}));
        check("imm_sign",  64'(out_imm_s),  64'({{16{e_inst[15]}}, e_inst[15:0]}));
        check("flush_cnt", 64'(flush_cnt0), 64'(m_cnt));
        check("cnt_sat",   64'(flush_cnt_c), 64'(m_cnt_c));
        if (rst) begin
            sb.delete();
            m_pc = '0; m_cnt = '0; m_cnt_c = '0;
        end else if (flush) begin
            if (n > 0 || in_valid) begin
                if (m_cnt != 16'hFFFF) m_cnt++;
                if (m_cnt_c != 2'b11)  m_cnt_c++;
            end
            sb.delete();
        end else begin
            if (out_ready && n > 0) void'(sb.pop_front());
            if (in_valid && n < 2) sb.push_back('{valid: 1'b1, inst: in_inst, pc: in_pc});
            if (sb.size() > 0) m_pc = sb[0].pc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [9:0] pc,
                         input logic ordy, input logic fl);
        in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    endtask

    initial begin
        m_pc = '0; m_cnt = '0; m_cnt_c = '0;
        rst = 1'b1;
        drive(1'b0, 32'h0, 10'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        cycle();
        check("rst_in_ready", 64'(in_ready0), 64'd1);
        check("rst_out_pc",   64'(out_pc0),   64'd0);
        rst = 1'b0;

        // single transfer, one-cycle latency
        drive(1'b1, 32'h2002_0005, 10'd4, 1'b1, 1'b0);
        cycle();
        check("first_inst", 64'(out_inst0), 64'h2002_0005);
        check("first_imm",  64'(out_imm0),  64'h0000_0005);
        drive(1'b0, 32'h0, 10'd0, 1'b1, 1'b0);
        cycle();

        // stall: A, B fill the stage, C must be ignored
        drive(1'b1, 32'hA000_0001, 10'd8, 1'b0, 1'b0);  cycle();
        drive(1'b1, 32'hB000_0002, 10'd12, 1'b0, 1'b0); cycle();
        check("stall_full", 64'(in_ready0), 64'd0);
        drive(1'b1, 32'hC000_0003, 10'd16, 1'b0, 1'b0); cycle();
        drive(1'b0, 32'h0, 10'd0, 1'b1, 1'b0);
        check("stall_A", 64'(out_inst0), 64'hA000_0001);
        cycle();
        check("stall_B", 64'(out_inst0), 64'hB000_0002);
        cycle();
        check("stall_empty", 64'(out_valid0), 64'd0);
        cycle();

        // flush in TWO with a same-cycle input
        drive(1'b1, 32'h1111_0001, 10'd20, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h2222_0002, 10'd24, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h3333_0003, 10'd28, 1'b0, 1'b1); cycle();
        check("flush_valid", 64'(out_valid0), 64'd0);
        check("flush_nop",   64'(out_inst0),  64'd0);
        check("flush_rdy",   64'(in_ready0),  64'd1);
        check("flush_one",   64'(flush_cnt0), 64'd1);
        check("flush_pc",    64'(out_pc0),    64'd20);
        drive(1'b0, 32'h0, 10'd0, 1'b1, 1'b1); cycle();
        check("flush_idle",  64'(flush_cnt0), 64'd1);

        // sign vs zero extension of 0xFFFC
        drive(1'b1, 32'h1234_FFFC, 10'd32, 1'b0, 1'b0); cycle();
        check("sext", 64'(out_imm_s), 64'hFFFF_FFFC);
        check("zext", 64'(out_imm0),  64'h0000_FFFC);

        // five effective flushes saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h5000_0000 + 32'(i), 10'd40, 1'b0, 1'b1);
            cycle();
        end
        check("sat3", 64'(flush_cnt_c), 64'd3);

        // reset in TWO with flush asserted
        drive(1'b1, 32'h6000_0001, 10'd44, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h6000_0002, 10'd48, 1'b0, 1'b0); cycle();
        rst = 1'b1;
        drive(1'b1, 32'h6000_0003, 10'd52, 1'b0, 1'b1); cycle();
        rst = 1'b0;
        check("rst2_valid", 64'(out_valid0), 64'd0);
        check("rst2_cnt",   64'(flush_cnt0), 64'd0);
        check("rst2_pc",    64'(out_pc0),    64'd0);
        drive(1'b1, 32'h7000_0007, 10'd56, 1'b1, 1'b0); cycle();
        check("post_rst", 64'(out_inst0), 64'h7000_0007);

        // random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 10'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            cycle();
        end
        drive(1'b0, 32'h0, 10'd0, 1'b1, 1'b0);
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
